// File: rtl/sig_gen_pkg.sv
// sig_gen_pkg: shared types and helpers for the sig_gen_pn pulse generator.
//   state_t        : controller state (IDLE, RUN)
//   LANES_DEF      : default lane count of the generator
//   LANES_W        : lane-index width for the default lane count
//   clamp_period() : raises a requested period to at least the lane count so
//                    that a single word can contain at most one wrap.
package sig_gen_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam int LANES_DEF = 16;
    localparam int LANES_W   = $clog2(LANES_DEF);

    // Works on a wide container; callers size-cast in and out.
    function automatic logic [63:0] clamp_period(input logic [63:0] period_req,
                                                 input logic [63:0] lanes);
        return (period_req < lanes) ? lanes : period_req;
    endfunction

endpackage

// File: rtl/sig_gen_pn_lane_mask.sv
// sig_lane_mask: combinational per-word lane evaluation.
//   ph        in  lane-0 phase of this word
//   period    in  period in force at the start of the word
//   high_old  in  on-time for lanes before the wrap
//   high_new  in  on-time for lanes from the wrap onward
//   wrap_en   in  0 blanks every lane from the wrap onward (graceful stop)
//   word      out output samples, lane 0 earliest
//   boundary  out one-hot of the wrap lane (zero when no wrap or wrap_en=0)
//   wrap_any  out some lane of this word wrapped
module sig_lane_mask #(
    parameter int LANES = 16,
    parameter int CNT_W = 32
) (
    input  logic [CNT_W-1:0] ph,
    input  logic [CNT_W-1:0] period,
    input  logic [CNT_W-1:0] high_old,
    input  logic [CNT_W-1:0] high_new,
    input  logic             wrap_en,
    output logic [LANES-1:0] word,
    output logic [LANES-1:0] boundary,
    output logic             wrap_any
);

    logic [LANES-1:0] wrapped;

    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_lane
            logic [CNT_W-1:0] q_raw;
            logic [CNT_W-1:0] q;
            logic [CNT_W-1:0] hi;
            assign q_raw       = ph + CNT_W'(gi);
            assign wrapped[gi] = (q_raw >= period);
            // period >= LANES, so one subtraction is always enough
            assign q           = wrapped[gi] ? (q_raw - period) : q_raw;
            assign hi          = wrapped[gi] ? high_new : high_old;
            assign word[gi]    = (q < hi) & (wrap_en | ~wrapped[gi]);
        end
    endgenerate

    // Once a lane wraps every later lane has wrapped too, so the first
    // wrapped lane is the rising edge of the wrapped vector.
    assign boundary = wrapped & ~{wrapped[LANES-2:0], 1'b0} & {LANES{wrap_en}};
    assign wrap_any = wrapped[LANES-1];

endmodule

// File: rtl/sig_gen_pn.sv
// sig_gen_pn: parallel-sample square/pulse generator feeding a serializer.
//   p_clock        in  clock
//   reset          in  synchronous, active-high reset
//   enable         in  run request (level); dropping it stops at a cycle end
//   period_in      in  requested period in samples (clamped to >= LANES)
//   high_in        in  requested on-time in samples
//   set_timing     in  strobe capturing period_in/high_in as pending timing
//   p_out          out LANES samples per clock, lane 0 earliest
//   p_cycle_start  out one-hot-or-zero marker of phase 0 of an emitted cycle
//   running        out high while in RUN
//   timing_pending out captured timing not yet applied
module sig_gen_pn
    import sig_gen_pkg::*;
#(
    parameter int LANES          = 16,
    parameter int CNT_W          = 32,
    parameter int INITIAL_PERIOD = 1600,
    parameter int INITIAL_HIGH   = 800
) (
    input  logic             p_clock,
    input  logic             reset,
    input  logic             enable,
    input  logic [CNT_W-1:0] period_in,
    input  logic [CNT_W-1:0] high_in,
    input  logic             set_timing,
    output logic [LANES-1:0] p_out,
    output logic [LANES-1:0] p_cycle_start,
    output logic             running,
    output logic             timing_pending
);

    localparam logic [CNT_W-1:0] LANES_C = CNT_W'(LANES);

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] ph_reg, ph_next;
    logic [CNT_W-1:0] period_reg, period_next;
    logic [CNT_W-1:0] high_reg, high_next;
    logic [CNT_W-1:0] pend_period_reg, pend_period_next;
    logic [CNT_W-1:0] pend_high_reg, pend_high_next;
    logic             pending_reg, pending_next;
    logic [LANES-1:0] out_reg, out_next;
    logic [LANES-1:0] start_reg, start_next;

    logic [LANES-1:0] mask_word;
    logic [LANES-1:0] mask_start;
    logic             mask_wrap;
    logic [CNT_W-1:0] high_after_wrap;

    // Pending timing takes effect at the wrap lane of the current word.
    assign high_after_wrap = pending_reg ? pend_high_reg : high_reg;

    sig_lane_mask #(
        .LANES (LANES),
        .CNT_W (CNT_W)
    ) u_lane_mask (
        .ph       (ph_reg),
        .period   (period_reg),
        .high_old (high_reg),
        .high_new (high_after_wrap),
        .wrap_en  (enable),
        .word     (mask_word),
        .boundary (mask_start),
        .wrap_any (mask_wrap)
    );

    always_ff @(posedge p_clock) begin
        if (reset) begin
            state_reg       <= IDLE;
            ph_reg          <= '0;
            period_reg      <= CNT_W'(INITIAL_PERIOD);
            high_reg        <= CNT_W'(INITIAL_HIGH);
            pend_period_reg <= CNT_W'(INITIAL_PERIOD);
            pend_high_reg   <= CNT_W'(INITIAL_HIGH);
            pending_reg     <= 1'b0;
            out_reg         <= '0;
            start_reg       <= '0;
        end else begin
            state_reg       <= state_next;
            ph_reg          <= ph_next;
            period_reg      <= period_next;
            high_reg        <= high_next;
            pend_period_reg <= pend_period_next;
            pend_high_reg   <= pend_high_next;
            pending_reg     <= pending_next;
            out_reg         <= out_next;
            start_reg       <= start_next;
        end
    end

    always_comb begin
        state_next       = state_reg;
        ph_next          = ph_reg;
        period_next      = period_reg;
        high_next        = high_reg;
        pend_period_next = pend_period_reg;
        pend_high_next   = pend_high_reg;
        pending_next     = pending_reg;
        out_next         = '0;
        start_next       = '0;

        case (state_reg)
            IDLE: begin
                ph_next = '0;
                if (enable) begin
                    state_next = RUN;
                    // Starting at ph = period makes lane 0 of the first word
                    // wrap to phase 0, so it is flagged like any other start.
                    if (pending_reg) begin
                        period_next  = pend_period_reg;
                        high_next    = pend_high_reg;
                        pending_next = 1'b0;
                        ph_next      = pend_period_reg;
                    end else begin
                        ph_next = period_reg;
                    end
                end
            end
            RUN: begin
                out_next   = mask_word;
                start_next = mask_start;
                if (mask_wrap) begin
                    if (enable) begin
                        ph_next = ph_reg + LANES_C - period_reg;
                        if (pending_reg) begin
                            period_next  = pend_period_reg;
                            high_next    = pend_high_reg;
                            pending_next = 1'b0;
                        end
                    end else begin
                        // Stop at the cycle end; pending timing is kept.
                        state_next = IDLE;
                        ph_next    = '0;
                    end
                end else begin
                    ph_next = ph_reg + LANES_C;
                end
            end
            default: begin
                state_next = IDLE;
                ph_next    = '0;
            end
        endcase

        // A new capture wins over the clear done when timing is applied.
        if (set_timing) begin
            pend_period_next = CNT_W'(clamp_period(64'(period_in), 64'(LANES)));
            pend_high_next   = high_in;
            pending_next     = 1'b1;
        end
    end

    assign p_out          = out_reg;
    assign p_cycle_start  = start_reg;
    assign running        = (state_reg == RUN);
    assign timing_pending = pending_reg;

endmodule
